// File: rtl/axi_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Package : axi_pkg
// Shared AXI4 encodings, FSM state types and helpers for the burst master.
// Rev     : 1.0
// ----------------------------------------------------------------------------
package axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY       = 2'b00;
    localparam logic [1:0] RESP_EXOKAY     = 2'b01;
    localparam logic [1:0] RESP_SLVERR     = 2'b10;
    localparam logic [1:0] RESP_DECERR     = 2'b11;
    localparam int         AXI_4K_BOUNDARY = 4096;

    typedef enum logic [2:0] {
        R_IDLE = 3'd0,
        R_CALC = 3'd1,
        R_ADDR = 3'd2,
        R_DATA = 3'd3,
        R_DONE = 3'd4
    } rd_state_t;

    typedef enum logic [2:0] {
        W_IDLE = 3'd0,
        W_CALC = 3'd1,
        W_ADDR = 3'd2,
        W_DATA = 3'd3,
        W_RESP = 3'd4,
        W_DONE = 3'd5
    } wr_state_t;

    function automatic logic [2:0] size_from_width(input int width);
        return 3'($clog2(width / 8));
    endfunction

    // Responses are ranked by their numeric code (DECERR worst).
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_burst_planner.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : axi_burst_planner
// Tracks address/remaining words of a transfer and sizes the next INCR burst.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module axi_burst_planner
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int LEN_WIDTH      = 16,
    parameter int MAX_BURST      = 16,
    parameter int BYTES_PER_BEAT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [LEN_WIDTH-1:0]  load_len,
    input  logic                  advance,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [LEN_WIDTH-1:0]  remaining,
    output logic [8:0]            next_beats
);

    localparam int OFFS = $clog2(BYTES_PER_BEAT);

    logic [12:0] page_bytes;
    logic [12:0] page_beats;
    logic [8:0]  cap;

    // Burst = min(remaining, MAX_BURST, beats left before the 4 KB page end).
    always_comb begin
        page_bytes = 13'(AXI_4K_BOUNDARY) - {1'b0, addr[11:0]};
        page_beats = page_bytes >> OFFS;
        cap        = 9'(MAX_BURST);
        if (32'(page_beats) < 32'(cap)) cap = 9'(page_beats);
        if (32'(remaining) < 32'(cap))  cap = 9'(remaining);
        next_beats = cap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr      <= '0;
            remaining <= '0;
        end else if (load) begin
            addr      <= load_addr & ~ADDR_WIDTH'(BYTES_PER_BEAT - 1);
            remaining <= load_len;
        end else if (advance) begin
            addr      <= addr + (ADDR_WIDTH'(next_beats) << OFFS);
            remaining <= remaining - LEN_WIDTH'(next_beats);
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_master_burst.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : axi_master_burst
// AXI4 master with independent read/write engines splitting transfers into bursts.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module axi_master_burst
    import axi_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int LEN_WIDTH  = 16,
    parameter int MAX_BURST  = 16
) (
    input  logic                    i_axi_clk,
    input  logic                    i_axi_rst,
    input  logic                    i_rd_start_stb,
    input  logic [ID_WIDTH-1:0]     i_rd_id,
    input  logic [ADDR_WIDTH-1:0]   i_rd_addr,
    input  logic [LEN_WIDTH-1:0]    i_rd_len,
    output logic                    o_rd_ready,
    output logic                    o_rd_done_stb,
    output logic [1:0]              o_rd_resp,
    input  logic                    i_wr_start_stb,
    input  logic [ID_WIDTH-1:0]     i_wr_id,
    input  logic [ADDR_WIDTH-1:0]   i_wr_addr,
    input  logic [LEN_WIDTH-1:0]    i_wr_len,
    output logic                    o_wr_ready,
    output logic                    o_wr_done_stb,
    output logic [1:0]              o_wr_resp,
    input  logic [DATA_WIDTH-1:0]   usr_w_tdata,
    input  logic [DATA_WIDTH/8-1:0] usr_w_tstrb,
    input  logic                    usr_w_tvalid,
    output logic                    usr_w_tready,
    output logic [DATA_WIDTH-1:0]   usr_r_tdata,
    output logic                    usr_r_tlast,
    output logic                    usr_r_tvalid,
    input  logic                    usr_r_tready,
    output logic [ADDR_WIDTH-1:0]   axi_awaddr,
    output logic [ID_WIDTH-1:0]     axi_awid,
    output logic [7:0]              axi_awlen,
    output logic [2:0]              axi_awsize,
    output logic [1:0]              axi_awburst,
    output logic                    axi_awvalid,
    input  logic                    axi_awready,
    output logic [DATA_WIDTH-1:0]   axi_wdata,
    output logic [DATA_WIDTH/8-1:0] axi_wstrb,
    output logic                    axi_wlast,
    output logic                    axi_wvalid,
    input  logic                    axi_wready,
    input  logic [1:0]              axi_bresp,
    input  logic                    axi_bvalid,
    output logic                    axi_bready,
    output logic [ADDR_WIDTH-1:0]   axi_araddr,
    output logic [ID_WIDTH-1:0]     axi_arid,
    output logic [7:0]              axi_arlen,
    output logic [2:0]              axi_arsize,
    output logic [1:0]              axi_arburst,
    output logic                    axi_arvalid,
    input  logic                    axi_arready,
    input  logic [DATA_WIDTH-1:0]   axi_rdata,
    input  logic [1:0]              axi_rresp,
    input  logic                    axi_rlast,
    input  logic                    axi_rvalid,
    output logic                    axi_rready
);

    localparam int BYTES = DATA_WIDTH / 8;

    rd_state_t               rd_state;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [LEN_WIDTH-1:0]    rd_remaining;
    logic [8:0]              rd_next, rd_beats, rd_cnt;
    logic                    rd_last_burst, rd_load, rd_adv, rd_beat;

    wr_state_t               wr_state;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [LEN_WIDTH-1:0]    wr_remaining;
    logic [8:0]              wr_next, wr_beats, wr_cnt;
    logic                    wr_last_burst, wr_load, wr_adv, wr_beat;

    assign axi_arsize  = size_from_width(DATA_WIDTH);
    assign axi_awsize  = size_from_width(DATA_WIDTH);
    assign axi_arburst = AXI_BURST_INCR;
    assign axi_awburst = AXI_BURST_INCR;

    assign rd_load = (rd_state == R_IDLE) && i_rd_start_stb;
    assign rd_adv  = (rd_state == R_CALC) && (rd_next != 9'd0);
    assign wr_load = (wr_state == W_IDLE) && i_wr_start_stb;
    assign wr_adv  = (wr_state == W_CALC) && (wr_next != 9'd0);

    axi_burst_planner #(
        .ADDR_WIDTH(ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH),
        .MAX_BURST(MAX_BURST), .BYTES_PER_BEAT(BYTES)
    ) u_rd_plan (
        .clk(i_axi_clk), .rst(i_axi_rst), .load(rd_load), .load_addr(i_rd_addr),
        .load_len(i_rd_len), .advance(rd_adv), .addr(rd_addr),
        .remaining(rd_remaining), .next_beats(rd_next)
    );

    axi_burst_planner #(
        .ADDR_WIDTH(ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH),
        .MAX_BURST(MAX_BURST), .BYTES_PER_BEAT(BYTES)
    ) u_wr_plan (
        .clk(i_axi_clk), .rst(i_axi_rst), .load(wr_load), .load_addr(i_wr_addr),
        .load_len(i_wr_len), .advance(wr_adv), .addr(wr_addr),
        .remaining(wr_remaining), .next_beats(wr_next)
    );

    // Read data path is a zero-latency pass-through while a burst is active.
    assign axi_rready   = (rd_state == R_DATA) && usr_r_tready;
    assign usr_r_tvalid = (rd_state == R_DATA) && axi_rvalid;
    assign usr_r_tdata  = axi_rdata;
    assign usr_r_tlast  = usr_r_tvalid && axi_rlast && rd_last_burst;
    assign rd_beat      = (rd_state == R_DATA) && axi_rvalid && usr_r_tready;

    always_ff @(posedge i_axi_clk or posedge i_axi_rst) begin
        if (i_axi_rst) begin
            rd_state      <= R_IDLE;
            axi_arvalid   <= 1'b0;
            axi_araddr    <= '0;
            axi_arlen     <= '0;
            axi_arid      <= '0;
            rd_beats      <= '0;
            rd_cnt        <= '0;
            rd_last_burst <= 1'b0;
            o_rd_resp     <= RESP_OKAY;
            o_rd_ready    <= 1'b1;
            o_rd_done_stb <= 1'b0;
        end else begin
            o_rd_done_stb <= 1'b0;
            case (rd_state)
                R_IDLE: if (i_rd_start_stb) begin
                    axi_arid   <= i_rd_id;
                    o_rd_resp  <= RESP_OKAY;
                    o_rd_ready <= 1'b0;
                    rd_state   <= R_CALC;
                end
                R_CALC: if (rd_next == 9'd0) begin
                    o_rd_done_stb <= 1'b1;
                    rd_state      <= R_DONE;
                end else begin
                    axi_araddr    <= rd_addr;
                    axi_arlen     <= 8'(rd_next - 9'd1);
                    rd_beats      <= rd_next;
                    rd_cnt        <= '0;
                    rd_last_burst <= (rd_remaining == LEN_WIDTH'(rd_next));
                    axi_arvalid   <= 1'b1;
                    rd_state      <= R_ADDR;
                end
                R_ADDR: if (axi_arready) begin
                    axi_arvalid <= 1'b0;
                    rd_state    <= R_DATA;
                end
                R_DATA: if (rd_beat) begin
                    o_rd_resp <= resp_max(o_rd_resp, axi_rresp);
                    rd_cnt    <= rd_cnt + 9'd1;
                    if (rd_cnt == rd_beats - 9'd1) begin
                        o_rd_done_stb <= rd_last_burst;
                        rd_state      <= rd_last_burst ? R_DONE : R_CALC;
                    end
                end
                R_DONE: begin
                    o_rd_ready <= 1'b1;
                    rd_state   <= R_IDLE;
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    assign axi_wvalid   = (wr_state == W_DATA) && usr_w_tvalid;
    assign usr_w_tready = (wr_state == W_DATA) && axi_wready;
    assign axi_wdata    = usr_w_tdata;
    assign axi_wstrb    = usr_w_tstrb;
    assign axi_wlast    = (wr_state == W_DATA) && (wr_cnt == wr_beats - 9'd1);
    assign wr_beat      = axi_wvalid && axi_wready;

    always_ff @(posedge i_axi_clk or posedge i_axi_rst) begin
        if (i_axi_rst) begin
            wr_state      <= W_IDLE;
            axi_awvalid   <= 1'b0;
            axi_awaddr    <= '0;
            axi_awlen     <= '0;
            axi_awid      <= '0;
            axi_bready    <= 1'b0;
            wr_beats      <= '0;
            wr_cnt        <= '0;
            wr_last_burst <= 1'b0;
            o_wr_resp     <= RESP_OKAY;
            o_wr_ready    <= 1'b1;
            o_wr_done_stb <= 1'b0;
        end else begin
            o_wr_done_stb <= 1'b0;
            case (wr_state)
                W_IDLE: if (i_wr_start_stb) begin
                    axi_awid   <= i_wr_id;
                    o_wr_resp  <= RESP_OKAY;
                    o_wr_ready <= 1'b0;
                    wr_state   <= W_CALC;
                end
                W_CALC: if (wr_next == 9'd0) begin
                    o_wr_done_stb <= 1'b1;
                    wr_state      <= W_DONE;
                end else begin
                    axi_awaddr    <= wr_addr;
                    axi_awlen     <= 8'(wr_next - 9'd1);
                    wr_beats      <= wr_next;
                    wr_cnt        <= '0;
                    wr_last_burst <= (wr_remaining == LEN_WIDTH'(wr_next));
                    axi_awvalid   <= 1'b1;
                    wr_state      <= W_ADDR;
                end
                W_ADDR: if (axi_awready) begin
                    axi_awvalid <= 1'b0;
                    wr_state    <= W_DATA;
                end
                W_DATA: if (wr_beat) begin
                    wr_cnt <= wr_cnt + 9'd1;
                    if (axi_wlast) begin
                        axi_bready <= 1'b1;
                        wr_state   <= W_RESP;
                    end
                end
                W_RESP: if (axi_bvalid) begin
                    axi_bready    <= 1'b0;
                    o_wr_resp     <= resp_max(o_wr_resp, axi_bresp);
                    o_wr_done_stb <= wr_last_burst;
                    wr_state      <= wr_last_burst ? W_DONE : W_CALC;
                end
                W_DONE: begin
                    o_wr_ready <= 1'b1;
                    wr_state   <= W_IDLE;
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_master_burst.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : tb_axi_master_burst
// Directed self-checking bench for axi_master_burst (32-bit data, 16-beat max).
// Rev    : 1.0
// ----------------------------------------------------------------------------
module tb_axi_master_burst;
    import axi_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_rd_start_stb = 0, i_wr_start_stb = 0;
    logic [3:0]  i_rd_id = 0, i_wr_id = 0;
    logic [31:0] i_rd_addr = 0, i_wr_addr = 0;
    logic [15:0] i_rd_len = 0, i_wr_len = 0;
    logic        o_rd_ready, o_rd_done_stb, o_wr_ready, o_wr_done_stb;
    logic [1:0]  o_rd_resp, o_wr_resp;
    logic [31:0] usr_w_tdata = 0;
    logic [3:0]  usr_w_tstrb = 0;
    logic        usr_w_tvalid = 0, usr_w_tready;
    logic [31:0] usr_r_tdata;
    logic        usr_r_tlast, usr_r_tvalid;
    logic        usr_r_tready = 1;
    logic [31:0] axi_awaddr, axi_araddr;
    logic [3:0]  axi_awid, axi_arid;
    logic [7:0]  axi_awlen, axi_arlen;
    logic [2:0]  axi_awsize, axi_arsize;
    logic [1:0]  axi_awburst, axi_arburst;
    logic        axi_awvalid, axi_arvalid;
    logic        axi_awready = 0, axi_arready = 0;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wlast, axi_wvalid;
    logic        axi_wready = 0;
    logic [1:0]  axi_bresp = 0;
    logic        axi_bvalid = 0, axi_bready;
    logic [31:0] axi_rdata = 0;
    logic [1:0]  axi_rresp = 0;
    logic        axi_rlast = 0, axi_rvalid = 0, axi_rready;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    axi_master_burst dut (
        .i_axi_clk(clk), .i_axi_rst(rst),
        .i_rd_start_stb(i_rd_start_stb), .i_rd_id(i_rd_id), .i_rd_addr(i_rd_addr),
        .i_rd_len(i_rd_len), .o_rd_ready(o_rd_ready), .o_rd_done_stb(o_rd_done_stb),
        .o_rd_resp(o_rd_resp),
        .i_wr_start_stb(i_wr_start_stb), .i_wr_id(i_wr_id), .i_wr_addr(i_wr_addr),
        .i_wr_len(i_wr_len), .o_wr_ready(o_wr_ready), .o_wr_done_stb(o_wr_done_stb),
        .o_wr_resp(o_wr_resp),
        .usr_w_tdata(usr_w_tdata), .usr_w_tstrb(usr_w_tstrb), .usr_w_tvalid(usr_w_tvalid),
        .usr_w_tready(usr_w_tready),
        .usr_r_tdata(usr_r_tdata), .usr_r_tlast(usr_r_tlast), .usr_r_tvalid(usr_r_tvalid),
        .usr_r_tready(usr_r_tready),
        .axi_awaddr(axi_awaddr), .axi_awid(axi_awid), .axi_awlen(axi_awlen),
        .axi_awsize(axi_awsize), .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid),
        .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .axi_araddr(axi_araddr), .axi_arid(axi_arid), .axi_arlen(axi_arlen),
        .axi_arsize(axi_arsize), .axi_arburst(axi_arburst), .axi_arvalid(axi_arvalid),
        .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_rd(input logic [31:0] a, input logic [15:0] l, input logic [3:0] id);
        @(negedge clk);
        i_rd_start_stb = 1; i_rd_addr = a; i_rd_len = l; i_rd_id = id;
        @(negedge clk);
        i_rd_start_stb = 0;
    endtask

    task automatic start_wr(input logic [31:0] a, input logic [15:0] l, input logic [3:0] id);
        @(negedge clk);
        i_wr_start_stb = 1; i_wr_addr = a; i_wr_len = l; i_wr_id = id;
        @(negedge clk);
        i_wr_start_stb = 0;
    endtask

    // Slave side of one read burst; returns on the negedge after the last beat.
    task automatic rd_burst(input logic [31:0] a, input logic [7:0] len, input bit fin,
                            input logic [1:0] resp, input logic [3:0] id);
        int n = 0;
        logic [31:0] d;
        while (axi_arvalid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk("ar_wait", axi_arvalid, 1);
        chk("araddr", axi_araddr, a);
        chk("arlen", axi_arlen, len);
        chk("arsize", axi_arsize, 2);
        chk("arburst", axi_arburst, 1);
        chk("arid", axi_arid, id);
        axi_arready = 1;
        @(negedge clk);
        axi_arready = 0;
        chk("arvalid_drop", axi_arvalid, 0);
        for (int i = 0; i <= int'(len); i++) begin
            d = $urandom;
            axi_rvalid = 1; axi_rdata = d; axi_rresp = resp;
            axi_rlast = (i == int'(len));
            #1;
            chk("rready", axi_rready, 1);
            chk("r_tvalid", usr_r_tvalid, 1);
            chk("r_tdata", usr_r_tdata, d);
            chk("r_tlast", usr_r_tlast, fin && (i == int'(len)));
            @(negedge clk);
        end
        axi_rvalid = 0; axi_rlast = 0; axi_rresp = 0;
        chk("rd_done_edge", o_rd_done_stb, fin);
    endtask

    // Slave side of one write burst including its B response.
    task automatic wr_burst(input logic [31:0] a, input logic [7:0] len, input bit fin,
                            input logic [1:0] resp, input logic [3:0] id);
        int n = 0;
        logic [31:0] d;
        logic [3:0]  s;
        while (axi_awvalid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk("aw_wait", axi_awvalid, 1);
        chk("awaddr", axi_awaddr, a);
        chk("awlen", axi_awlen, len);
        chk("awsize", axi_awsize, 2);
        chk("awburst", axi_awburst, 1);
        chk("awid", axi_awid, id);
        axi_awready = 1;
        @(negedge clk);
        axi_awready = 0;
        chk("awvalid_drop", axi_awvalid, 0);
        for (int i = 0; i <= int'(len); i++) begin
            d = $urandom;
            s = 4'(i) | 4'b0001;
            usr_w_tvalid = 1; usr_w_tdata = d; usr_w_tstrb = s; axi_wready = 1;
            #1;
            chk("wvalid", axi_wvalid, 1);
            chk("w_tready", usr_w_tready, 1);
            chk("wdata", axi_wdata, d);
            chk("wstrb", axi_wstrb, s);
            chk("wlast", axi_wlast, i == int'(len));
            @(negedge clk);
        end
        usr_w_tvalid = 0; axi_wready = 0;
        chk("bready_up", axi_bready, 1);
        chk("wvalid_gap", axi_wvalid, 0);
        axi_bvalid = 1; axi_bresp = resp;
        @(negedge clk);
        axi_bvalid = 0; axi_bresp = 0;
        chk("bready_down", axi_bready, 0);
        chk("wr_done_edge", o_wr_done_stb, fin);
    endtask

    initial begin
        int n;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_rd_ready", o_rd_ready, 1);
        chk("rst_wr_ready", o_wr_ready, 1);
        chk("rst_arvalid", axi_arvalid, 0);
        chk("rst_awvalid", axi_awvalid, 0);
        chk("rst_bready", axi_bready, 0);
        chk("rst_rready", axi_rready, 0);
        chk("rst_done", {o_rd_done_stb, o_wr_done_stb}, 0);
        chk("rst_resp", {o_rd_resp, o_wr_resp}, 0);
        rst = 0;
        @(negedge clk);

        // Read 8 words at 0x1000: single burst
        start_rd(32'h1000, 16'd8, 4'd3);
        chk("rd_busy", o_rd_ready, 0);
        rd_burst(32'h1000, 8'd7, 1, RESP_OKAY, 4'd3);
        chk("rd1_resp", o_rd_resp, RESP_OKAY);
        @(negedge clk);
        chk("rd1_done_once", o_rd_done_stb, 0);
        chk("rd1_ready", o_rd_ready, 1);

        // Write 40 words at 0x2000: 16 + 16 + 8
        start_wr(32'h2000, 16'd40, 4'd1);
        chk("wr_busy", o_wr_ready, 0);
        wr_burst(32'h2000, 8'd15, 0, RESP_OKAY, 4'd1);
        wr_burst(32'h2040, 8'd15, 0, RESP_OKAY, 4'd1);
        wr_burst(32'h2080, 8'd7, 1, RESP_OKAY, 4'd1);
        chk("wr2_resp", o_wr_resp, RESP_OKAY);
        @(negedge clk);
        chk("wr2_done_once", o_wr_done_stb, 0);
        chk("wr2_ready", o_wr_ready, 1);

        // Read 10 words at 0x0FF0: split at the 4 KB page, EXOKAY on first burst
        start_rd(32'h0FF0, 16'd10, 4'd5);
        rd_burst(32'h0FF0, 8'd3, 0, RESP_EXOKAY, 4'd5);
        rd_burst(32'h1000, 8'd5, 1, RESP_OKAY, 4'd5);
        chk("rd3_resp", o_rd_resp, RESP_EXOKAY);
        @(negedge clk);

        // Write 20 words at 0x3000 with SLVERR on the first burst
        start_wr(32'h3000, 16'd20, 4'd2);
        wr_burst(32'h3000, 8'd15, 0, RESP_SLVERR, 4'd2);
        wr_burst(32'h3040, 8'd3, 1, RESP_OKAY, 4'd2);
        chk("wr4_resp", o_wr_resp, RESP_SLVERR);
        @(negedge clk);

        // Simultaneous read and write strobes
        @(negedge clk);
        i_rd_start_stb = 1; i_rd_addr = 32'h5000; i_rd_len = 16'd4; i_rd_id = 4'd6;
        i_wr_start_stb = 1; i_wr_addr = 32'h6000; i_wr_len = 16'd4; i_wr_id = 4'd7;
        @(negedge clk);
        i_rd_start_stb = 0; i_wr_start_stb = 0;
        chk("both_busy", {o_rd_ready, o_wr_ready}, 0);
        fork
            rd_burst(32'h5000, 8'd3, 1, RESP_OKAY, 4'd6);
            wr_burst(32'h6000, 8'd3, 1, RESP_OKAY, 4'd7);
        join
        chk("both_resp", {o_rd_resp, o_wr_resp}, 0);
        @(negedge clk);
        chk("both_ready", {o_rd_ready, o_wr_ready}, 2'b11);

        // Zero-length read: done two cycles after the strobe, no AR
        start_rd(32'h7000, 16'd0, 4'd0);
        chk("len0_early", o_rd_done_stb, 0);
        @(negedge clk);
        chk("len0_done", o_rd_done_stb, 1);
        chk("len0_resp", o_rd_resp, RESP_OKAY);
        chk("len0_noar", axi_arvalid, 0);
        @(negedge clk);
        chk("len0_ready", o_rd_ready, 1);

        // Asynchronous reset during the third write beat
        start_wr(32'h4000, 16'd8, 4'd9);
        n = 0;
        while (axi_awvalid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk("rstw_aw_wait", axi_awvalid, 1);
        axi_awready = 1;
        @(negedge clk);
        axi_awready = 0;
        usr_w_tvalid = 1; axi_wready = 1;
        repeat (2) @(negedge clk);
        #1;
        chk("rstw_beat3_valid", axi_wvalid, 1);
        #1 rst = 1;
        #1;
        chk("rstw_wvalid", axi_wvalid, 0);
        chk("rstw_awvalid", axi_awvalid, 0);
        chk("rstw_bready", axi_bready, 0);
        chk("rstw_ready", o_wr_ready, 1);
        usr_w_tvalid = 0; axi_wready = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("rstw_after_ready", o_wr_ready, 1);
        chk("rstw_no_done", o_wr_done_stb, 0);
        start_wr(32'h0, 16'd1, 4'd4);
        wr_burst(32'h0, 8'd0, 1, RESP_OKAY, 4'd4);
        chk("rstw_next_resp", o_wr_resp, RESP_OKAY);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
